self_test_sequencer: RTL
========================

Name: self_test_sequencer

Overview:
- Synthesizable on-board self-test controller for the RISC machine top level; it brings the same checks the simulation bench performs onto the board.
- Walks data memory and compares it against an expected-image ROM, then holds and releases CPU reset.
- Waits for the HALT rising edge, then checks the PC and one result word in memory.
- Reports pass/fail plus a fail code and fail address on LEDR/HEX via the top level.
- Owns the memory read port except while the CPU runs.

Parameters:
DATA_W, 16, memory word width
ADDR_W, 8, memory address width
PC_W, 9, CPU program counter width
CHECK_WORDS, 22, number of image words checked, addresses 0..CHECK_WORDS-1
RESULT_ADDR, 8'h14, address of the result word
EXPECT_RESULT, 16'd900, required result word
EXPECT_PC, 9'hF, required PC at HALT
MAX_CYCLES, 4096, halt timeout in cycles (only used with TIMEOUT_EN)

Ports:
CLOCK_50  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset (top level drives it from KEY[1])
start  in  1  level; sampled only in IDLE
mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous latency
exp_rdata  in  DATA_W  expected-image ROM data, same latency, addressed by mem_addr
halt  in  1  CPU HALT indicator (LEDR[8] source)
pc  in  PC_W  CPU PC
mem_addr  out  ADDR_W  sequencer read address
mem_sel  out  1  1 = sequencer owns memory port; 0 = CPU owns it
cpu_reset_n  out  1  active-low CPU reset
busy  out  1  high in every state except IDLE/PASS/FAIL
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
fail_code  out  3  0 none, 1 image, 2 PC, 3 result, 4 timeout
fail_addr  out  ADDR_W  mismatching address (codes 1/3), else 0

Behaviour:
- Reset (async, reset_n=0): state IDLE; mem_addr=0, mem_sel=1, cpu_reset_n=0, busy=0, done=0, pass=0, fail_code=0, fail_addr=0, halt_q=0, counters=0. Deasserting mid-test restarts from IDLE; no partial result is kept.
- IDLE: cpu_reset_n=0, mem_sel=1. If start=1, clear fail_code/fail_addr/pass, set addr=0, go to IMG_RD.
- IMG_RD: drive mem_addr=addr; go to IMG_CMP next cycle.
- IMG_CMP: compare mem_rdata with exp_rdata using full 4-state equality (X/Z is a mismatch in sim).
  - Mismatch: fail_code=1, fail_addr=addr, go to FAIL.
  - Match and addr==CHECK_WORDS-1: go to RUN.
  - Match otherwise: addr+1, go to IMG_RD.
  - Image check of N words takes exactly 2N cycles.
- RUN: one cycle with cpu_reset_n=0, mem_sel=0; sample halt_q<=halt; go to WAIT_HALT.
- WAIT_HALT: cpu_reset_n=1, mem_sel=0; halt_q<=halt each cycle.
  - Rising edge (halt & ~halt_q) required; a halt already high on entry is ignored until it falls and rises again.
  - On the edge: if pc!=EXPECT_PC, fail_code=2, go to FAIL; else go to RES_RD.
- RES_RD: cpu_reset_n stays 1 (CPU state preserved), mem_sel=1, mem_addr=RESULT_ADDR.
- RES_CMP:
  - mem_rdata==EXPECT_RESULT: go to PASS.
  - Otherwise: fail_code=3, fail_addr=RESULT_ADDR, go to FAIL.
- PASS/FAIL are sticky.
  - done=1; cpu_reset_n keeps its last value; mem_sel=1.
  - start=1 re-enters IMG_RD, clearing results as in IDLE.
  - start during any busy state is ignored.
- halt asserted during the image check is ignored (CPU held in reset).

Optional Feature:
TIMEOUT_EN
- Defined: a cycle counter (width clog2(MAX_CYCLES)+1) clears on RUN entry and increments in WAIT_HALT. When it reaches MAX_CYCLES with no halt edge, set fail_code=4, go to FAIL, and drive cpu_reset_n=0. A halt edge on the same cycle as the timeout wins.
- Undefined: no counter; WAIT_HALT waits indefinitely and fail_code 4 is never produced.

Test Plan:
- Memory model loaded with correct 22-word program image, CPU model halting with pc=9'hF and mem[0x14]=900, start pulse -> cpu_reset_n rises exactly 45 cycles after start is sampled (44 image cycles + RUN), then pass=1, done=1, fail_code=0.
- Corrupt mem[6]=16'h0000 -> fail_code=1, fail_addr=6, pass=0, cpu_reset_n never deasserts, done after 14 cycles.
- CPU halts with pc=9'h10 -> fail_code=2, fail_addr=0.
- mem[0x14]=0 at halt -> fail_code=3, fail_addr=8'h14.
- With TIMEOUT_EN and MAX_CYCLES=64, halt held low -> fail_code=4 exactly 64 cycles after WAIT_HALT entry, cpu_reset_n=0. Without TIMEOUT_EN -> busy stays 1.
- reset_n pulsed low during WAIT_HALT, and halt already high at RUN -> immediate IDLE with all outputs at reset values; after restart, a stuck-high halt produces no false pass.

Source files
------------

// File: rtl/self_test_sequencer_if.sv
// Memory read port shared between the self-test sequencer and the data-memory/ROM side.
// The sequencer drives the address and port-ownership select; memory and ROM return data one cycle later.
interface self_test_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] exp_rdata;

  modport master (output mem_addr, output mem_sel, input mem_rdata, input exp_rdata);
  modport slave  (input mem_addr, input mem_sel, output mem_rdata, output exp_rdata);
endinterface

// File: rtl/self_test_sequencer.sv
// On-board self-test: image check, CPU run until HALT edge, PC and result-word check.
// Define TIMEOUT_EN to add a MAX_CYCLES halt timeout (fail code 4).
module self_test_sequencer #(
  parameter int                DATA_W        = 16,
  parameter int                ADDR_W        = 8,
  parameter int                PC_W          = 9,
  parameter int                CHECK_WORDS   = 22,
  parameter logic [ADDR_W-1:0] RESULT_ADDR   = 8'h14,
  parameter logic [DATA_W-1:0] EXPECT_RESULT = 16'd900,
  parameter logic [PC_W-1:0]   EXPECT_PC     = 9'hF,
  parameter int                MAX_CYCLES    = 4096
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  halt,
  input  logic [PC_W-1:0]       pc,
  self_test_sequencer_if.master mem_if,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            fail_code,
  output logic [ADDR_W-1:0]     fail_addr
);

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_IMAGE   = 3'd1;
  localparam logic [2:0] FC_PC      = 3'd2;
  localparam logic [2:0] FC_RESULT  = 3'd3;
  localparam logic [2:0] FC_TIMEOUT = 3'd4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHECK_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, IMG_RD, IMG_CMP, RUN, WAIT_HALT, RES_RD, RES_CMP, PASS, FAIL
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_sel_q;
  logic              cpu_reset_n_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [2:0]        fail_code_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic              halt_q;
  logic              halt_edge;
  logic              timeout;

  assign halt_edge = halt & ~halt_q;

`ifdef TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] cyc_d;

  assign cyc_d   = cyc_q + 1'b1;
  assign timeout = (cyc_d == CNT_W'(MAX_CYCLES));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
    end else if (state_q == RUN) begin
      cyc_q <= '0;
    end else if (state_q == WAIT_HALT) begin
      cyc_q <= cyc_d;
    end
  end
`else
  assign timeout = 1'b0;
  // MAX_CYCLES has no effect unless the timeout is built in.
  if (MAX_CYCLES < 1) begin : g_max_cycles_unused
  end
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      mem_sel_q     <= 1'b1;
      cpu_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= FC_NONE;
      fail_addr_q   <= '0;
      halt_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE, PASS, FAIL: begin
          if (start) begin
            state_q       <= IMG_RD;
            mem_addr_q    <= '0;
            mem_sel_q     <= 1'b1;
            cpu_reset_n_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_code_q   <= FC_NONE;
            fail_addr_q   <= '0;
          end
        end
        IMG_RD: state_q <= IMG_CMP;
        IMG_CMP: begin
          // Case inequality so an X/Z word from memory counts as a mismatch.
          if (mem_if.mem_rdata !== mem_if.exp_rdata) begin
            state_q     <= FAIL;
            fail_code_q <= FC_IMAGE;
            fail_addr_q <= mem_addr_q;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (mem_addr_q == LAST_ADDR) begin
            state_q   <= RUN;
            mem_sel_q <= 1'b0;
          end else begin
            state_q    <= IMG_RD;
            mem_addr_q <= mem_addr_q + 1'b1;
          end
        end
        RUN: begin
          halt_q        <= halt;
          cpu_reset_n_q <= 1'b1;
          state_q       <= WAIT_HALT;
        end
        WAIT_HALT: begin
          halt_q <= halt;
          if (halt_edge) begin
            mem_sel_q <= 1'b1;
            if (pc != EXPECT_PC) begin
              state_q     <= FAIL;
              fail_code_q <= FC_PC;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q    <= RES_RD;
              mem_addr_q <= RESULT_ADDR;
            end
          end else if (timeout) begin
            state_q       <= FAIL;
            fail_code_q   <= FC_TIMEOUT;
            mem_sel_q     <= 1'b1;
            cpu_reset_n_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end
        end
        RES_RD: state_q <= RES_CMP;
        RES_CMP: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (mem_if.mem_rdata === EXPECT_RESULT) begin
            state_q <= PASS;
            pass_q  <= 1'b1;
          end else begin
            state_q     <= FAIL;
            fail_code_q <= FC_RESULT;
            fail_addr_q <= RESULT_ADDR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_if.mem_addr = mem_addr_q;
  assign mem_if.mem_sel  = mem_sel_q;
  assign cpu_reset_n     = cpu_reset_n_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_code       = fail_code_q;
  assign fail_addr       = fail_addr_q;

endmodule
